// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, defaults and helpers for the RX and TX paths
package uart_pkg;

   // Default clk cycles per serial bit (even, at least 4)
   localparam int UART_OVERSAMPLE  = 8;
   // Default number of data bits per frame
   localparam int UART_FRAME_WIDTH = 8;

   // Frame FSM states, common to receiver and transmitter
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // 2-of-3 vote used to filter single-sample line noise
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit oversample counter and 3-sample majority voter
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
   input  logic clk,
   input  logic reset,
   input  logic i_rx,
   input  logic i_start,
   input  logic i_active,
   output logic o_sample_done,
   output logic o_bit_val,
   output logic o_bit_end
);

   localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] CNT_MID_LO = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_MID    = CW'(OVERSAMPLE / 2);
   localparam logic [CW-1:0] CNT_MID_HI = CW'(OVERSAMPLE / 2 + 1);

   logic [CW-1:0] r_cnt;
   logic          r_smp_lo;
   logic          r_smp_mid;

   // Bit-cycle counter plus capture of the first two mid-bit samples; the start
   // detect cycle is counter 0, so the counter resumes at 1 on the following cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_smp_lo  <= 1'b1;
         r_smp_mid <= 1'b1;
      end else begin
         if (i_start) begin
            r_cnt <= CNT_ONE;
         end else if (!i_active) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_ONE;
         end
         if (i_active && (r_cnt == CNT_MID_LO)) begin
            r_smp_lo <= i_rx;
         end
         if (i_active && (r_cnt == CNT_MID)) begin
            r_smp_mid <= i_rx;
         end
      end
   end

   // Third sample is the live line value, so the vote is ready at counter MID_HI
   assign o_sample_done = i_active && (r_cnt == CNT_MID_HI);
   assign o_bit_val     = majority3(r_smp_lo, r_smp_mid, i_rx);
   assign o_bit_end     = i_active && (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - oversampled UART receiver with parity and stop checking
module uart_rx_deserializer
   import uart_pkg::*;
#(
   parameter int FRAME_WIDTH = UART_FRAME_WIDTH,
   parameter int OVERSAMPLE  = UART_OVERSAMPLE
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   RX_IN,
   input  logic                   PAR_EN,
   input  logic                   PAR_TYP,
   output logic [FRAME_WIDTH-1:0] P_DATA,
   output logic                   data_valid,
   output logic                   par_err,
   output logic                   stp_err
);

   localparam int IW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_WIDTH - 1);

   logic                   r_sync1;
   logic                   r_sync2;
   uart_state_t            r_state;
   logic                   r_armed;
   logic [IW-1:0]          r_bit_idx;
   logic [FRAME_WIDTH-1:0] r_shift;
   logic                   r_par_en;
   logic                   r_par_typ;
   logic                   r_par_bit;

   logic w_rx_s;
   logic w_active;
   logic w_start_det;
   logic w_sample_done;
   logic w_bit_val;
   logic w_bit_end;
   logic w_exp_par;

   // Two-flop synchronizer; resets to the idle (high) line level
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= RX_IN;
         r_sync2 <= r_sync1;
      end
   end

   assign w_rx_s      = r_sync2;
   assign w_active    = (r_state != ST_IDLE);
   assign w_start_det = (r_state == ST_IDLE) && r_armed && !w_rx_s;
   assign w_exp_par   = r_par_typ ? ~^r_shift : ^r_shift;

   uart_rx_sampler #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_sampler (
      .clk           (clk),
      .reset         (reset),
      .i_rx          (w_rx_s),
      .i_start       (w_start_det),
      .i_active      (w_active),
      .o_sample_done (w_sample_done),
      .o_bit_val     (w_bit_val),
      .o_bit_end     (w_bit_end)
   );

   // Frame FSM with registered data word and one-cycle outcome pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_armed    <= 1'b0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_par_en   <= 1'b0;
         r_par_typ  <= 1'b0;
         r_par_bit  <= 1'b0;
         P_DATA     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;

         // Only idle-level high (IDLE or the stop bit) arms detection; high data
         // bits must not, or a break after a stop error would look like a start
         if (w_rx_s && ((r_state == ST_IDLE) || (r_state == ST_STOP))) begin
            r_armed <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_start_det) begin
                  r_state   <= ST_START;
                  r_armed   <= 1'b0;
                  r_bit_idx <= '0;
                  r_par_en  <= PAR_EN;
                  r_par_typ <= PAR_TYP;
               end
            end

            ST_START: begin
               if (w_sample_done && w_bit_val) begin
                  r_state <= ST_IDLE;
               end else if (w_bit_end) begin
                  r_state <= ST_DATA;
               end
            end

            ST_DATA: begin
               if (w_sample_done) begin
                  r_shift <= {w_bit_val, r_shift[FRAME_WIDTH-1:1]};
               end
               if (w_bit_end) begin
                  if (r_bit_idx == IDX_LAST) begin
                     r_bit_idx <= '0;
                     r_state   <= r_par_en ? ST_PARITY : ST_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + IDX_ONE;
                  end
               end
            end

            ST_PARITY: begin
               if (w_sample_done) begin
                  r_par_bit <= w_bit_val;
               end
               if (w_bit_end) begin
                  r_state <= ST_STOP;
               end
            end

            ST_STOP: begin
               if (w_sample_done) begin
                  r_state <= ST_IDLE;
                  if (!w_bit_val) begin
                     stp_err <= 1'b1;
                     r_armed <= 1'b0;
                  end else if (r_par_en && (r_par_bit != w_exp_par)) begin
                     par_err <= 1'b1;
                  end else begin
                     data_valid <= 1'b1;
                     P_DATA     <= r_shift;
                  end
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
